// File: rtl/ram_access_ctrl.sv
// ============================================================================
// Module     : ram_access_ctrl
// Description: Burst read/write sequencer for a negedge-sampled single-port
//              word RAM. Optional range check: RAM_ACCESS_RANGE_CHK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_access_ctrl #(
    parameter int DEPTH = 128,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_len,
    input  logic          wdat_valid,
    output logic          wdat_ready,
    input  logic [DW-1:0] wdat,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          rsp_err,
    output logic          done,
    output logic          done_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    len_q, len_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          oor_q, oor_d;
    logic          pending_q, pending_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_wr_q, mem_wr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rd_q, mem_rd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_last_q, rsp_last_d;
    logic          rsp_err_q, rsp_err_d;
    logic          done_q, done_d;
    logic          done_err_q, done_err_d;

    logic          req_oor;
    logic          beats_left;
    logic [AW-1:0] addr_next;

`ifdef RAM_ACCESS_RANGE_CHK_EN
    assign req_oor = (req_addr > LAST_ADDR);
`else
    assign req_oor = 1'b0;
`endif

    // cnt_q counts beats already issued; the burst has len_q+1 beats
    assign beats_left = (cnt_q <= {1'b0, len_q});
    assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        oor_d       = oor_q;
        pending_d   = pending_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        done_d      = 1'b0;
        done_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    len_d     = req_len;
                    cnt_d     = '0;
                    oor_d     = req_oor;
                    pending_d = 1'b0;
                    state_d   = req_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (beats_left) begin
                    if (wdat_valid) begin
                        if (!oor_q) begin
                            mem_wr_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = wdat;
                        end
                        addr_d = addr_next;
                        cnt_d  = cnt_q + 3'd1;
                    end
                end else begin
                    done_d     = 1'b1;
                    done_err_d = oor_q;
                    state_d    = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
                // A beat can only be in flight while the response slot is free
                if (pending_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = oor_q ? '0 : mem_rdata;
                    rsp_last_d  = (cnt_q == ({1'b0, len_q} + 3'd1));
                    rsp_err_d   = oor_q;
                    pending_d   = 1'b0;
                end else if (beats_left && (!rsp_valid_q || rsp_ready)) begin
                    if (!oor_q) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = addr_q;
                    end
                    pending_d = 1'b1;
                    addr_d    = addr_next;
                    cnt_d     = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            oor_q       <= 1'b0;
            pending_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            oor_q       <= oor_d;
            pending_q   <= pending_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign wdat_ready = (state_q == ST_WRITE) && beats_left;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_err    = rsp_err_q;
    assign done       = done_q;
    assign done_err   = done_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rd     = mem_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// ============================================================================
// Module     : tb_ram_access_ctrl
// Description: Scoreboard bench for ram_access_ctrl with a negedge RAM model.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_access_ctrl;
    localparam int DEPTH = 128;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_len = '0;
    logic          wdat_valid = 1'b0, wdat_ready;
    logic [DW-1:0] wdat = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_last, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          done, done_err;
    logic [AW-1:0] mem_addr;
    logic          mem_wr, mem_rd;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    ram_access_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .done(done), .done_err(done_err),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    // RAM device: samples on negedge, drives high-Z when not reading
    logic [DW-1:0] ram [DEPTH];
    always @(negedge clock) begin
        if (mem_wr) ram[int'(mem_addr) % DEPTH] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[int'(mem_addr) % DEPTH];
        else        mem_rdata <= 'z;
    end

    // Reference memory contents as seen by completed writes
    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [DW-1:0] data; logic last; logic err; } rsp_t;
    wr_t  exp_wr_q[$];
    rsp_t exp_rsp_q[$];
    bit   exp_done_q[$];
    int   hs_cyc_q[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, last_wr_cyc = 0, rd_cnt = 0;
    int bp_mode = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event occurred, required it not to", name);
    endtask

    function automatic int nxt(input int a);
        return (a == DEPTH - 1) ? 0 : (a + 1) % (1 << AW);
    endfunction

    // Monitor / scoreboard
    wr_t  mw;
    rsp_t mr;
    bit   me;
    bit   held = 0;
    logic [DW-1:0] held_data;
    always @(negedge clock) begin
        if (!reset_n) begin
            held = 0;
        end else begin
            if (mem_wr) begin
                if (exp_wr_q.size() == 0) fail("unexpected_write");
                else begin
                    mw = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(mw.addr));
                    chk("wr_data", 64'(mem_wdata), 64'(mw.data));
                end
                last_wr_cyc = cyc;
            end
            if (mem_rd) rd_cnt++;
            if (done) begin
                if (exp_done_q.size() == 0) fail("unexpected_done");
                else begin
                    me = exp_done_q.pop_front();
                    chk("done_err", 64'(done_err), 64'(me));
                    chk("done_after_beats", 64'(exp_wr_q.size()), 64'd0);
                    if (!me) chk("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
                end
            end
            if (held) begin
                chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                chk("rsp_hold_data", 64'(rsp_data), 64'(held_data));
            end
            held      = rsp_valid && !rsp_ready;
            held_data = rsp_data;
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) fail("unexpected_rsp");
                else begin
                    mr = exp_rsp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(mr.data));
                    chk("rsp_last", 64'(rsp_last), 64'(mr.last));
                    chk("rsp_err", 64'(rsp_err), 64'(mr.err));
                end
                hs_cyc_q.push_back(cyc);
            end
        end
    end

    // Consumer back-pressure: 0 = always ready, 1 = random, 2 = manual
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (bp_mode == 0)      rsp_ready = 1'b1;
            else if (bp_mode == 1) rsp_ready = ($urandom_range(3, 0) != 0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin @(posedge clock); #1; n++; end
        if (!req_ready) fail("req_ready_timeout");
    endtask

    task automatic send_req(input bit wr, input int addr, input int len);
        wait_ready();
        req_valid = 1'b1; req_wr = wr; req_addr = AW'(addr); req_len = 2'(len);
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rsp_q.size() != 0 || exp_done_q.size() != 0 || !req_ready) && n < 300) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 300) fail("drain_timeout");
    endtask

    task automatic do_write(input int addr, input int len, input logic [DW-1:0] base,
                            input bit rnd, input int gmin, input int gmax);
        int a = addr;
        bit oor = (addr >= DEPTH);
        logic [DW-1:0] d;
        wr_t w;
        exp_done_q.push_back(oor);
        send_req(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            int g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) begin
                wdat_valid = 1'b0;
                @(posedge clock); #1;
                chk("gap_mem_wr", 64'(mem_wr), 64'd0);
            end
            d = rnd ? DW'($urandom) : base + DW'(i);
            wdat = d; wdat_valid = 1'b1;
            if (!wdat_ready) fail("wdat_ready_low");
            if (!oor) begin
                w.addr = AW'(a); w.data = d;
                exp_wr_q.push_back(w);
                ref_mem[a] = d;
            end
            @(posedge clock); #1;
            a = nxt(a);
        end
        wdat_valid = 1'b0;
        drain();
    endtask

    task automatic do_read(input int addr, input int len);
        int a = addr;
        bit oor = (addr >= DEPTH);
        rsp_t r;
        for (int i = 0; i <= len; i++) begin
            r.data = '0;
            if (!oor) r.data = ref_mem[a];
            r.last = (i == len); r.err = oor;
            exp_rsp_q.push_back(r);
            a = nxt(a);
        end
        send_req(1'b0, addr, len);
        drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0;
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        repeat (3) @(posedge clock);
        #1;
        chk("reset_mem_wr", 64'(mem_wr), 64'd0);
        chk("reset_mem_rd", 64'(mem_rd), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_done", 64'({done, done_err, rsp_last, rsp_err}), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);

        // Single write then read-back
        do_write(0, 0, 32'h22450000, 1'b0, 0, 0);
        do_read(0, 0);

        // Wrapping burst and read throughput
        do_write(126, 3, 32'd1, 1'b0, 0, 0);
        hs_cyc_q.delete();
        do_read(126, 3);
        chk("rd_beats", 64'(hs_cyc_q.size()), 64'd4);
        if (hs_cyc_q.size() == 4)
            chk("rd_throughput", 64'(hs_cyc_q[3] - hs_cyc_q[0]), 64'd6);

        // Back-pressure on a 3-beat read
        bp_mode = 2; rsp_ready = 1'b0;
        begin
            rsp_t r;
            int a = 126;
            for (int i = 0; i < 3; i++) begin
                r.data = ref_mem[a]; r.last = (i == 2); r.err = 1'b0;
                exp_rsp_q.push_back(r);
                a = nxt(a);
            end
        end
        send_req(1'b0, 126, 2);
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clock); #1; n++; end
        if (!rsp_valid) fail("bp_rsp_timeout");
        d0 = rsp_data;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            chk("bp_data_stable", 64'(rsp_data), 64'(d0));
            chk("bp_no_reissue", 64'(mem_rd), 64'd0);
        end
        bp_mode = 0; rsp_ready = 1'b1;
        drain();

        // Write with data gaps
        do_write(40, 1, 32'hA5A50000, 1'b0, 3, 3);
        do_read(40, 1);

        // Asynchronous reset in the middle of a write burst
        begin
            wr_t w;
            send_req(1'b1, 10, 3);
            wdat = 32'h0000AAAA; wdat_valid = 1'b1;
            w.addr = AW'(10); w.data = wdat; exp_wr_q.push_back(w);
            ref_mem[10] = wdat;
            @(posedge clock); #1;
            wdat = 32'h0000BBBB;
            w.addr = AW'(11); w.data = wdat; exp_wr_q.push_back(w);
            @(posedge clock); #1;
            reset_n = 1'b0;
            #1;
            chk("midrst_mem_wr", 64'(mem_wr), 64'd0);
            chk("midrst_outputs", 64'({mem_rd, rsp_valid, rsp_last, rsp_err, done, done_err}), 64'd0);
            chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
            chk("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
            wdat_valid = 1'b0;
            exp_wr_q.delete();
            @(posedge clock); #1;
            reset_n = 1'b1;
            @(posedge clock); #1;
            chk("postrst_req_ready", 64'(req_ready), 64'd1);
            chk("postrst_mem_wr_rd", 64'({mem_wr, mem_rd}), 64'd0);
            do_read(10, 1);
        end

`ifdef RAM_ACCESS_RANGE_CHK_EN
        begin
            int rd_before = rd_cnt;
            do_read(200, 1);
            chk("oor_no_mem_rd", 64'(rd_cnt), 64'(rd_before));
            do_write(300, 0, 32'h12345678, 1'b0, 0, 0);
        end
`endif

        // Randomized traffic
        bp_mode = 1;
        for (int t = 0; t < 40; t++) begin
            int a = int'($urandom_range(DEPTH - 1, 0));
            int l = int'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) do_write(a, l, '0, 1'b1, 0, 2);
            else                           do_read(a, l);
        end
        bp_mode = 0;
        drain();
        chk("scoreboard_empty", 64'(exp_wr_q.size() + exp_rsp_q.size() + exp_done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
